sw_input_port: RTL



---
 rtl/sw_input_pkg.sv | 29 ++
 rtl/sw_input_port_debounce.sv | 69 ++++++
 rtl/sw_input_port.sv | 110 +++++++++++
 3 files changed

// File: rtl/sw_input_pkg.sv
// Shared definitions for the switch input port: register window layout,
// default base address and the word-select decode used by the read path.
package sw_input_pkg;

  localparam logic [3:0]  SW_OFF_STATE    = 4'h0;
  localparam logic [3:0]  SW_OFF_EDGE     = 4'h4;
  localparam logic [3:0]  SW_OFF_RAW      = 4'h8;
  localparam int          SW_WIN_BYTES    = 16;
  localparam logic [31:0] SW_DEFAULT_BASE = 32'h1001_0000;

  typedef enum logic [1:0] {
    SW_SEL_STATE = 2'd0,
    SW_SEL_EDGE  = 2'd1,
    SW_SEL_RAW   = 2'd2,
    SW_SEL_ZERO  = 2'd3
  } sw_sel_e;

  // Map a word index inside the window to the register it selects; the
  // byte-lane bits are ignored so unaligned accesses hit the aligned word.
  function automatic sw_sel_e sw_decode(input logic [1:0] word_idx);
    logic [3:0] word_off;
    word_off = {word_idx, 2'b00};
    if (word_off == SW_OFF_STATE)     return SW_SEL_STATE;
    else if (word_off == SW_OFF_EDGE) return SW_SEL_EDGE;
    else if (word_off == SW_OFF_RAW)  return SW_SEL_RAW;
    else                              return SW_SEL_ZERO;
  endfunction

endpackage

// File: rtl/sw_input_port_debounce.sv
// One switch bit: 2-flop synchronizer, tick-paced debounce counter, the
// accepted (stable) level and a one-cycle pulse when that level changes.
module sw_debounce_bit
  import sw_input_pkg::*;
#(
  parameter int STABLE_CNT = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sw_i,
  input  logic tick_i,
  output logic sync_o,
  output logic stable_o,
  output logic edge_o
);

  localparam int CW = $clog2(STABLE_CNT + 1);

  logic          meta_q;
  logic          sync_q;
  logic          stable_q, stable_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          edge_d;

  // Bring the asynchronous switch into the clock domain; nothing else sees sw_i.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= sw_i;
      sync_q <= meta_q;
    end
  end

  // On each tick count consecutive disagreements; the last one flips the level.
  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    edge_d   = 1'b0;
    if (tick_i) begin
      if (sync_q == stable_q) begin
        cnt_d = '0;
      end else if (cnt_q == CW'(STABLE_CNT - 1)) begin
        stable_d = ~stable_q;
        cnt_d    = '0;
        edge_d   = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Debounce state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  assign sync_o   = sync_q;
  assign stable_o = stable_q;
  assign edge_o   = edge_d;

endmodule

// File: rtl/sw_input_port.sv
// Switch input port: synchronizes and debounces the raw switch bus and
// exposes STATE / EDGE (sticky, clear-on-read) / RAW as a read-only
// 16-byte load window. Define SW_IRQ_EN to add the registered o_irq output.
module sw_input_port
  import sw_input_pkg::*;
#(
  parameter int          DW         = 32,
  parameter int          TICK_DIV   = 1000,
  parameter int          STABLE_CNT = 4,
  parameter logic [31:0] BASE_ADDR  = SW_DEFAULT_BASE
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic [DW-1:0] i_io_sw,
  input  logic [31:0]   i_lsu_addr,
  input  logic          i_lsu_rden,
  output logic [31:0]   o_ld_data,
  output logic          o_ld_vld,
  output logic [DW-1:0] o_sw_stable
`ifdef SW_IRQ_EN
  ,
  output logic          o_irq
`endif
);

  localparam int PW = $clog2(TICK_DIV);

  logic [PW-1:0] presc_q, presc_d;
  logic          tick;
  logic [DW-1:0] sync, stable, new_edge;
  logic [DW-1:0] edge_q, edge_d, clr;
  logic [31:0]   offset, rd_word, ld_data_d;
  logic [31:0]   ld_data_q;
  logic          ld_vld_q;
  logic          in_win, rd_hit;
  sw_sel_e       sel;

  // Debounce sample tick: one cycle out of every TICK_DIV.
  always_comb begin
    tick    = (presc_q == PW'(TICK_DIV - 1));
    presc_d = tick ? '0 : presc_q + PW'(1);
  end

  // Prescaler register.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) presc_q <= '0;
    else         presc_q <= presc_d;
  end

  for (genvar b = 0; b < DW; b++) begin : g_bit
    sw_debounce_bit #(.STABLE_CNT(STABLE_CNT)) u_bit (
      .clk_i    (i_clk),
      .rst_i    (i_reset),
      .sw_i     (i_io_sw[b]),
      .tick_i   (tick),
      .sync_o   (sync[b]),
      .stable_o (stable[b]),
      .edge_o   (new_edge[b])
    );
  end

  // Window decode, read mux and EDGE clear; a fresh edge beats a same-cycle clear.
  always_comb begin
    offset  = i_lsu_addr - BASE_ADDR;
    in_win  = (offset < 32'(SW_WIN_BYTES));
    rd_hit  = i_lsu_rden && in_win;
    sel     = sw_decode(offset[3:2]);
    rd_word = '0;
    unique case (sel)
      SW_SEL_STATE: rd_word[DW-1:0] = stable;
      SW_SEL_EDGE:  rd_word[DW-1:0] = edge_q;
      SW_SEL_RAW:   rd_word[DW-1:0] = sync;
      default:      rd_word         = '0;
    endcase
    clr       = (rd_hit && sel == SW_SEL_EDGE) ? '1 : '0;
    edge_d    = (edge_q & ~clr) | new_edge;
    ld_data_d = rd_hit ? rd_word : '0;
  end

  // Sticky edge register and registered load response.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      edge_q    <= '0;
      ld_data_q <= '0;
      ld_vld_q  <= 1'b0;
    end else begin
      edge_q    <= edge_d;
      ld_data_q <= ld_data_d;
      ld_vld_q  <= rd_hit;
    end
  end

  assign o_ld_data   = ld_data_q;
  assign o_ld_vld    = ld_vld_q;
  assign o_sw_stable = stable;

`ifdef SW_IRQ_EN
  logic irq_q;

  // Interrupt follows whether any edge will be pending after this cycle.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) irq_q <= 1'b0;
    else         irq_q <= |edge_d;
  end

  assign o_irq = irq_q;
`else
`endif

endmodule
